// File: rtl/sim_run_ctrl_if.sv
//------------------------------------------------------------------------------
// Module      : sim_run_ctrl_if
// Description : Control/config/verdict bundle between the harness and the run controller.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface sim_run_ctrl_if #(
    parameter int CNT_W = 64,
    parameter int RST_W = 8,
    parameter int HB_W  = 32
);
    logic             start;
    logic [RST_W-1:0] cfg_reset_cycles;
    logic [CNT_W-1:0] cfg_max_cycles;
    logic [CNT_W-1:0] cfg_dump_start;
    logic             finish_req;
    logic             fail_req;
    logic             heartbeat;
    logic [HB_W-1:0]  cfg_hb_limit;

    logic             dut_reset;
    logic [CNT_W-1:0] run_cycles;
    logic             dump_en;
    logic             done;
    logic             pass;
    logic             fail;
    logic [1:0]       fail_reason;

    modport master (
        output start, cfg_reset_cycles, cfg_max_cycles, cfg_dump_start,
               finish_req, fail_req, heartbeat, cfg_hb_limit,
        input  dut_reset, run_cycles, dump_en, done, pass, fail, fail_reason
    );

    modport slave (
        input  start, cfg_reset_cycles, cfg_max_cycles, cfg_dump_start,
               finish_req, fail_req, heartbeat, cfg_hb_limit,
        output dut_reset, run_cycles, dump_en, done, pass, fail, fail_reason
    );
endinterface

`default_nettype wire

// File: rtl/sim_run_ctrl.sv
//------------------------------------------------------------------------------
// Module      : sim_run_ctrl
// Description : Run controller: DUT reset sequencing, cycle count/timeout, verdict
//               latch and dump window. Optional hang detector: RUN_CTRL_HEARTBEAT_EN.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sim_run_ctrl #(
    parameter int CNT_W        = 64,
    parameter int RST_W        = 8,
    parameter int DRAIN_CYCLES = 16,
    parameter int HB_W         = 32
) (
    input  logic          clock,
    input  logic          reset,
    sim_run_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_RST_HOLD = 3'd1,
        S_RUN      = 3'd2,
        S_DRAIN    = 3'd3,
        S_DONE     = 3'd4
    } state_t;

    localparam int c_DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES + 1) : 1;
    localparam logic [c_DRAIN_W-1:0] c_DRAIN_LAST =
        c_DRAIN_W'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);

    state_t               r_state;
    state_t               w_state_nx;
    logic [RST_W-1:0]     r_hold;
    logic [c_DRAIN_W-1:0] r_drain;
    logic [CNT_W-1:0]     r_run_cycles;
    logic [CNT_W-1:0]     w_run_nx;
    logic                 r_dut_reset;
    logic                 r_dump_en;
    logic                 r_done;
    logic                 r_pass;
    logic                 r_fail;
    logic [1:0]           r_reason;

    logic                 w_start_ok;
    logic [RST_W-1:0]     w_hold_last;
    logic                 w_timeout;
    logic                 w_hang;
    logic                 w_fail_now;
    logic                 w_pass_now;
    logic [1:0]           w_reason_nx;
    logic                 w_cnt_en;
    logic                 w_dump_nx;

    assign w_start_ok  = bus.start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_hold_last = (bus.cfg_reset_cycles == '0) ? '0
                                                      : bus.cfg_reset_cycles - RST_W'(1);
    assign w_timeout   = (bus.cfg_max_cycles != '0) && (r_run_cycles == bus.cfg_max_cycles);

`ifdef RUN_CTRL_HEARTBEAT_EN
    logic [HB_W-1:0] r_hb_cnt;

    // Cleared outside RUN so every run starts with a fresh idle count.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_hb_cnt <= '0;
        end else if ((r_state != S_RUN) || bus.heartbeat) begin
            r_hb_cnt <= '0;
        end else if (r_hb_cnt != '1) begin
            r_hb_cnt <= r_hb_cnt + HB_W'(1);
        end
    end

    assign w_hang = (bus.cfg_hb_limit != '0) && (r_hb_cnt == bus.cfg_hb_limit);
`else
    logic            w_heartbeat_unused;
    logic [HB_W-1:0] w_hb_limit_unused;

    assign w_heartbeat_unused = bus.heartbeat;
    assign w_hb_limit_unused  = bus.cfg_hb_limit;
    assign w_hang             = 1'b0;
`endif

    always_comb begin
        w_state_nx  = r_state;
        w_fail_now  = 1'b0;
        w_pass_now  = 1'b0;
        w_reason_nx = 2'd0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_state_nx = S_RST_HOLD;
                end
            end
            S_RST_HOLD: begin
                if (r_hold == w_hold_last) begin
                    w_state_nx = S_RUN;
                end
            end
            S_RUN: begin
                if (bus.fail_req) begin
                    w_state_nx  = S_DONE;
                    w_fail_now  = 1'b1;
                    w_reason_nx = 2'd1;
                end else if (w_timeout) begin
                    w_state_nx  = S_DONE;
                    w_fail_now  = 1'b1;
                    w_reason_nx = 2'd2;
                end else if (w_hang) begin
                    w_state_nx  = S_DONE;
                    w_fail_now  = 1'b1;
                    w_reason_nx = 2'd3;
                end else if (bus.finish_req) begin
                    if (DRAIN_CYCLES == 0) begin
                        w_state_nx = S_DONE;
                        w_pass_now = 1'b1;
                    end else begin
                        w_state_nx = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (bus.fail_req) begin
                    w_state_nx  = S_DONE;
                    w_fail_now  = 1'b1;
                    w_reason_nx = 2'd1;
                end else if (r_drain == c_DRAIN_LAST) begin
                    w_state_nx = S_DONE;
                    w_pass_now = 1'b1;
                end
            end
            S_DONE: begin
                if (bus.start) begin
                    w_state_nx = S_RST_HOLD;
                end
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    // A cycle that ends the run in failure is not counted as completed.
    assign w_cnt_en = ((r_state == S_RUN) || (r_state == S_DRAIN)) && !w_fail_now;

    always_comb begin
        w_run_nx = r_run_cycles;
        if (w_start_ok) begin
            w_run_nx = '0;
        end else if (w_cnt_en && (r_run_cycles != '1)) begin
            w_run_nx = r_run_cycles + CNT_W'(1);
        end
    end

    // Dump window looks one edge ahead so the registered output lines up with run_cycles.
    always_comb begin
        w_dump_nx = 1'b0;
        if ((w_state_nx == S_RST_HOLD) && (bus.cfg_dump_start == '0)) begin
            w_dump_nx = 1'b1;
        end else if (((w_state_nx == S_RUN) || (w_state_nx == S_DRAIN)) &&
                     (w_run_nx >= bus.cfg_dump_start)) begin
            w_dump_nx = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_hold       <= '0;
            r_drain      <= '0;
            r_run_cycles <= '0;
            r_dut_reset  <= 1'b1;
            r_dump_en    <= 1'b0;
        end else begin
            r_state      <= w_state_nx;
            r_hold       <= (r_state == S_RST_HOLD) ? r_hold + RST_W'(1) : '0;
            r_drain      <= (r_state == S_DRAIN) ? r_drain + c_DRAIN_W'(1) : '0;
            r_run_cycles <= w_run_nx;
            r_dut_reset  <= (w_state_nx == S_IDLE) || (w_state_nx == S_RST_HOLD);
            r_dump_en    <= w_dump_nx;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_done   <= 1'b0;
            r_pass   <= 1'b0;
            r_fail   <= 1'b0;
            r_reason <= 2'd0;
        end else if (w_start_ok) begin
            r_done   <= 1'b0;
            r_pass   <= 1'b0;
            r_fail   <= 1'b0;
            r_reason <= 2'd0;
        end else if ((w_state_nx == S_DONE) && (r_state != S_DONE)) begin
            r_done   <= 1'b1;
            r_pass   <= w_pass_now;
            r_fail   <= w_fail_now;
            r_reason <= w_reason_nx;
        end
    end

    assign bus.dut_reset   = r_dut_reset;
    assign bus.run_cycles  = r_run_cycles;
    assign bus.dump_en     = r_dump_en;
    assign bus.done        = r_done;
    assign bus.pass        = r_pass;
    assign bus.fail        = r_fail;
    assign bus.fail_reason = r_reason;

endmodule

`default_nettype wire
